// File: rtl/id_ex_pipe_reg.sv
// Decode->execute pipeline register: valid/ready handshake, synchronous flush and
// an optional two-entry skid buffer so a stall never forms a combinational ready path.
module id_ex_pipe_reg #(
  parameter int CTRL_W = 24,
  parameter int DATA_W = 128,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              accept, pop;

  // With the skid entry, ready depends only on a register, never on out_ready.
  assign in_ready  = (SKID != 0) ? ~skid_valid : (~main_valid | out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl & {CTRL_W{main_valid}};
  assign out_data  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      // Data is left in place; only control is scrubbed so no stale enable survives.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else if (SKID != 0) begin
      if (!main_valid || pop) begin
        if (skid_valid) begin
          main_valid <= 1'b1;
          main_ctrl  <= skid_ctrl;
          main_data  <= skid_data;
          skid_valid <= 1'b0;
        end else if (accept) begin
          main_valid <= 1'b1;
          main_ctrl  <= in_ctrl;
          main_data  <= in_data;
        end else begin
          main_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_ctrl  <= in_ctrl;
        skid_data  <= in_data;
      end
    end else begin
      if (accept) begin
        main_valid <= 1'b1;
        main_ctrl  <= in_ctrl;
        main_data  <= in_data;
      end else if (pop) begin
        main_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Drives a SKID=1 and a SKID=0 instance with shared stimulus; each is compared
// every cycle against its own queue-based reference model.
module tb_id_ex_pipe_reg;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [23:0]  in_ctrl;
  logic [127:0] in_data;

  logic         rdy1, vld1, rdy0, vld0;
  logic [23:0]  ctrl1, ctrl0;
  logic [127:0] data1, data0;
  logic [1:0]   occ1, occ0;

  int checks = 0;
  int failures = 0;

  // Reference state: FIFO contents and the data value left on the outputs.
  logic [23:0]  qc1[$], qc0[$];
  logic [127:0] qd1[$], qd0[$];
  logic [127:0] last1, last0;
  int           acc1;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.CTRL_W(24), .DATA_W(128), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(vld1), .out_ready(out_ready),
    .out_ctrl(ctrl1), .out_data(data1), .occupancy(occ1));

  id_ex_pipe_reg #(.CTRL_W(24), .DATA_W(128), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(vld0), .out_ready(out_ready),
    .out_ctrl(ctrl0), .out_data(data0), .occupancy(occ0));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("s1_valid", vld1, qc1.size() > 0);
    chk("s1_ctrl",  ctrl1, qc1.size() > 0 ? qc1[0] : 24'h0);
    chk("s1_data",  data1, last1);
    chk("s1_occ",   occ1, qc1.size());
    chk("s0_valid", vld0, qc0.size() > 0);
    chk("s0_ctrl",  ctrl0, qc0.size() > 0 ? qc0[0] : 24'h0);
    chk("s0_data",  data0, last0);
    chk("s0_occ",   occ0, qc0.size());
  endtask

  task automatic model_clear();
    qc1.delete(); qd1.delete(); qc0.delete(); qd0.delete();
    last1 = '0; last0 = '0;
  endtask

  // One clock: drive at negedge, check ready, advance models, check after edge.
  task automatic tick(input logic iv, input logic [23:0] c, input logic [127:0] d,
                      input logic ordy, input logic fl);
    bit r1, r0, a1, a0, p1, p0;
    @(negedge clk);
    in_valid = iv; in_ctrl = c; in_data = d; out_ready = ordy; flush = fl;
    #1;
    r1 = qc1.size() < 2;
    r0 = (qc0.size() == 0) || ordy;
    chk("s1_in_ready", rdy1, r1);
    chk("s0_in_ready", rdy0, r0);
    a1 = iv & r1 & ~fl;  a0 = iv & r0 & ~fl;
    p1 = (qc1.size() > 0) && ordy;
    p0 = (qc0.size() > 0) && ordy;
    if (p1) begin void'(qc1.pop_front()); void'(qd1.pop_front()); end
    if (p0) begin void'(qc0.pop_front()); void'(qd0.pop_front()); end
    if (fl) begin
      qc1.delete(); qd1.delete(); qc0.delete(); qd0.delete();
    end else begin
      if (a1) begin qc1.push_back(c); qd1.push_back(d); end
      if (a0) begin qc0.push_back(c); qd0.push_back(d); end
    end
    if (qd1.size() > 0) last1 = qd1[0];
    if (qd0.size() > 0) last0 = qd0[0];
    acc1 = a1;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    logic [23:0] sc;
    int          sent;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    model_clear();
    #12;
    chk("rst_s1_in_ready", rdy1, 1'b1);
    chk("rst_s0_in_ready", rdy0, 1'b1);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;

    // Streaming: 8 back-to-back entries with execute always ready.
    for (int i = 0; i < 8; i++) tick(1'b1, 24'(i + 1), 128'(8'hA0 + i), 1'b1, 1'b0);
    tick(1'b0, '0, '0, 1'b1, 1'b0);

    // Stall/skid: A, B, C offered while execute stalls for 4 cycles, then release.
    sc = 24'h00A; sent = 0;
    for (int i = 0; i < 4; i++) begin
      tick(sent < 3, sc, 128'(sc) << 8, 1'b0, 1'b0);
      if (acc1 != 0 && sent < 3) begin sc = sc + 24'h1; sent++; end
    end
    for (int i = 0; i < 5; i++) begin
      tick(sent < 3, sc, 128'(sc) << 8, 1'b1, 1'b0);
      if (acc1 != 0 && sent < 3) begin sc = sc + 24'h1; sent++; end
    end

    // Flush with two held entries and a live input.
    tick(1'b1, 24'hFFFFFF, 128'h1111, 1'b0, 1'b0);
    tick(1'b1, 24'hFFFFFF, 128'h2222, 1'b0, 1'b0);
    tick(1'b1, 24'hFFFFFF, 128'h3333, 1'b0, 1'b1);
    tick(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush coinciding with a pop and a valid input at occupancy 1.
    tick(1'b1, 24'h00BEEF, 128'h4444, 1'b0, 1'b0);
    tick(1'b1, 24'h00CAFE, 128'h5555, 1'b1, 1'b1);
    tick(1'b0, '0, '0, 1'b1, 1'b0);

    // Reset pulsed between edges with two entries held.
    tick(1'b1, 24'h000123, 128'h6666, 1'b0, 1'b0);
    tick(1'b1, 24'h000456, 128'h7777, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    model_clear();
    chk("midrst_s1_in_ready", rdy1, 1'b1);
    chk("midrst_s0_in_ready", rdy0, 1'b1);
    check_outputs();
    #1 reset = 1'b0;
    tick(1'b1, 24'h000789, 128'h8888, 1'b0, 1'b0);

    // Random handshake with unique data per cycle and occasional flush.
    for (int i = 0; i < 600; i++) begin
      tick(1'($urandom_range(0, 3) != 0), 24'($urandom), {32'(i), 96'($urandom)},
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0));
    end
    for (int i = 0; i < 3; i++) tick(1'b0, '0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
